accion_heroe: RTL
=================

# accion_heroe

Hero action sequencer for the endless-runner game mode. It decodes keypad move commands into timed hero actions: fly, jump or duck. Each action is held for a fixed number of frame ticks, followed by a cooldown. The block also judges each obstacle reaching the hero column against the current action, and maintains score, lives and game-over status. It sits between the keypad decoder / top-level screen FSM and the hero sprite renderer and score display.

## Interface
- `T_ACCION`, 8: frame ticks an action is held (1..255)
- `T_ENFRIA`, 2: cooldown ticks after an action (0..255)
- `T_INMUNE`, 6: invulnerability ticks after a hit (1..255)
- `VIDAS`, 3: lives loaded at game start (1..3)

Ports:
- `clk` input 1: system clock
- `rst` input 1: asynchronous, active-high reset
- `tick` input 1: one-cycle frame-tick pulse
- `presente` input 4: top-level screen state; 4'd3 = juego (game running)
- `keypad_pressed` input 1: key valid strobe
- `key` input 5: key code; 2 = fly, 6 = jump, 8 = duck
- `obs_valid` input 1: one-cycle pulse when an obstacle reaches the hero column
- `obs_aleo` input 4: obstacle type, valid with `obs_valid`
- `mov` output 2: hero action; 0 = run, 1 = fly, 2 = jump, 3 = duck
- `busy` output 1: high in ACCION, ENFRIA and GOLPE
- `hit` output 1: one-cycle pulse on collision
- `score` output 8: obstacles cleared, saturating
- `vidas` output 2: lives remaining
- `game_over` output 1: sticky end-of-game flag

## Operation
- Active only while `presente == 4'd3`. Otherwise:
  - FSM is forced to IDLE; `mov` = 0; counters are cleared.
  - `score`, `vidas` and `game_over` hold their values for display.
- Game start: on the first cycle `presente == 3` after a cycle `!= 3` (registered previous value):
  - `score` <= 0, `vidas` <= VIDAS, `game_over` <= 0, FSM <= IDLE.
  - Keys and obstacles are ignored on that cycle.
- FSM states: IDLE, ACCION, ENFRIA, GOLPE, FIN.
  - IDLE: `keypad_pressed` with `key` ∈ {2, 6, 8} loads `mov` with 1/2/3, counter <= T_ACCION, goes to ACCION. Other key codes are ignored.
  - ACCION: counter decrements on `tick`. On the tick that takes it to 0: `mov` <= 0, counter <= T_ENFRIA, go to ENFRIA (straight to IDLE if T_ENFRIA == 0).
  - ENFRIA: counter decrements on `tick`; reaching 0 goes to IDLE.
  - Keypresses in ACCION, ENFRIA, GOLPE and FIN are dropped, with no queueing.
  - GOLPE: `mov` = 0; counter <= T_INMUNE on entry, decrements on `tick`, returns to IDLE at 0. Obstacles in GOLPE produce neither hit nor score.
  - FIN: absorbing until the next game start or `rst`. `mov` = 0, `game_over` = 1, all inputs are ignored.
- Obstacle judgement on `obs_valid`, in any state except GOLPE and FIN:
  - Required `mov` per `obs_aleo`: 1 (ground) needs 2; 2 (overhead) needs 3; 3 (pit) needs 1.
  - `obs_aleo` 0 and 4..15 are no obstacle and require nothing.
  - Match, or no obstacle: `score` += 1, saturating at 255.
  - Mismatch: `hit` pulses and `vidas` -= 1. If the new `vidas` == 0, go to FIN; otherwise go to GOLPE, aborting any action or cooldown.
- Judgement uses the registered `mov` of the current cycle.

## Timing
- Reset values: `mov` 0, `busy` 0, `hit` 0, `score` 0, `vidas` VIDAS, `game_over` 0, FSM IDLE, counters 0.
- All outputs are registered. A keypress at cycle n produces `mov` and `busy` at n+1.
- `hit`, `score` and `vidas` update at n+1 after `obs_valid` at n.
- Action duration counts T_ACCION `tick` pulses after entry. A tick in the accept cycle does not count.
- Simultaneous events:
  - Keypress and `obs_valid` in IDLE: the obstacle is judged with `mov` = 0, and the hit takes priority over the keypress.
  - Hit and action expiry on the same tick: the hit wins and the FSM goes to GOLPE.
  - `presente` leaving 3 mid-action: `mov` = 0 on the next cycle.
- `rst` mid-operation returns all outputs to their reset values immediately, asynchronously.

## Test plan
- Reset, then `presente`=3, key 6 pulse, 8 ticks → `mov`=2 from the next cycle for exactly 8 ticks, then 0; `busy` drops 2 ticks later.
- IDLE, `obs_aleo`=1 `obs_valid` → `hit` pulse, `vidas` 3→2, 6-tick GOLPE. A second obstacle during GOLPE is ignored, so `score` and `vidas` are unchanged.
- Key 8, then `obs_aleo`=2 during ACCION → `score` 0→1, no `hit`. Key 2 pressed during ACCION is dropped, so `mov` stays 3.
- Three mismatched obstacles spaced beyond immunity → `vidas` 0, `game_over`=1, `mov` stuck at 0. Setting `presente` to 2 then back to 3 → `score` 0, `vidas` 3, `game_over` 0.
- Force `score` to 255 via 255 cleared obstacles, then one more clear → `score` stays 255. `obs_aleo`=7 counts as a clear.
- Assert `rst` mid-ACCION → `mov` 0, `busy` 0, `vidas` 3 without waiting for a clock edge.

Source files
------------

// File: rtl/accion_heroe.sv
// Hero action sequencer: turns keypad moves into timed fly/jump/duck actions,
// judges obstacles against the current action and keeps score, lives and game-over.
module accion_heroe #(
  parameter int T_ACCION = 8,
  parameter int T_ENFRIA = 2,
  parameter int T_INMUNE = 6,
  parameter int VIDAS    = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic [3:0] presente,
  input  logic       keypad_pressed,
  input  logic [4:0] key,
  input  logic       obs_valid,
  input  logic [3:0] obs_aleo,
  output logic [1:0] mov,
  output logic       busy,
  output logic       hit,
  output logic [7:0] score,
  output logic [1:0] vidas,
  output logic       game_over
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCION,
    S_ENFRIA,
    S_GOLPE,
    S_FIN
  } estado_t;

  localparam logic [7:0] CNT_ACCION = 8'(T_ACCION);
  localparam logic [7:0] CNT_ENFRIA = 8'(T_ENFRIA);
  localparam logic [7:0] CNT_INMUNE = 8'(T_INMUNE);
  localparam logic [1:0] VIDAS_INI  = 2'(VIDAS);

  estado_t    estado_q, estado_d;
  logic [7:0] cnt_q, cnt_d;
  logic [1:0] mov_q, mov_d;
  logic       hit_q, hit_d;
  logic [7:0] score_q, score_d;
  logic [1:0] vidas_q, vidas_d;
  logic       go_q, go_d;
  logic       juego_q;

  logic       juego;
  logic       inicio;
  logic       choque;
  logic [1:0] mov_req;
  logic [1:0] mov_key;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? 8'hFF : v + 8'd1;
  endfunction

  // Action that clears each obstacle type; 0 means nothing to dodge.
  function automatic logic [1:0] req_mov(input logic [3:0] aleo);
    case (aleo)
      4'd1:    return 2'd2;
      4'd2:    return 2'd3;
      4'd3:    return 2'd1;
      default: return 2'd0;
    endcase
  endfunction

  function automatic logic [1:0] key_to_mov(input logic [4:0] k);
    case (k)
      5'd2:    return 2'd1;
      5'd6:    return 2'd2;
      5'd8:    return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  assign juego   = (presente == 4'd3);
  assign inicio  = juego && !juego_q;
  assign mov_req = req_mov(obs_aleo);
  assign mov_key = key_to_mov(key);

  always_comb begin
    estado_d = estado_q;
    cnt_d    = cnt_q;
    mov_d    = mov_q;
    hit_d    = 1'b0;
    score_d  = score_q;
    vidas_d  = vidas_q;
    go_d     = go_q;
    choque   = 1'b0;

    if (!juego) begin
      estado_d = S_IDLE;
      cnt_d    = 8'd0;
      mov_d    = 2'd0;
    end else if (inicio) begin
      estado_d = S_IDLE;
      cnt_d    = 8'd0;
      mov_d    = 2'd0;
      score_d  = 8'd0;
      vidas_d  = VIDAS_INI;
      go_d     = 1'b0;
    end else begin
      if (obs_valid && estado_q != S_GOLPE && estado_q != S_FIN) begin
        if (mov_req == 2'd0 || mov_req == mov_q) begin
          score_d = sat_inc8(score_q);
        end else begin
          choque  = 1'b1;
          hit_d   = 1'b1;
          vidas_d = vidas_q - 2'd1;
          mov_d   = 2'd0;
          if (vidas_q == 2'd1) begin
            estado_d = S_FIN;
            cnt_d    = 8'd0;
            go_d     = 1'b1;
          end else begin
            estado_d = S_GOLPE;
            cnt_d    = CNT_INMUNE;
          end
        end
      end

      // A hit overrides whatever the action FSM would have done this cycle.
      if (!choque) begin
        case (estado_q)
          S_IDLE: begin
            if (keypad_pressed && mov_key != 2'd0) begin
              estado_d = S_ACCION;
              mov_d    = mov_key;
              cnt_d    = CNT_ACCION;
            end
          end
          S_ACCION: begin
            if (tick) begin
              if (cnt_q == 8'd1) begin
                mov_d = 2'd0;
                if (CNT_ENFRIA == 8'd0) begin
                  estado_d = S_IDLE;
                  cnt_d    = 8'd0;
                end else begin
                  estado_d = S_ENFRIA;
                  cnt_d    = CNT_ENFRIA;
                end
              end else begin
                cnt_d = cnt_q - 8'd1;
              end
            end
          end
          S_ENFRIA, S_GOLPE: begin
            if (tick) begin
              if (cnt_q == 8'd1) begin
                estado_d = S_IDLE;
                cnt_d    = 8'd0;
              end else begin
                cnt_d = cnt_q - 8'd1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado_q <= S_IDLE;
      cnt_q    <= 8'd0;
      mov_q    <= 2'd0;
      hit_q    <= 1'b0;
      score_q  <= 8'd0;
      vidas_q  <= VIDAS_INI;
      go_q     <= 1'b0;
      juego_q  <= 1'b0;
    end else begin
      estado_q <= estado_d;
      cnt_q    <= cnt_d;
      mov_q    <= mov_d;
      hit_q    <= hit_d;
      score_q  <= score_d;
      vidas_q  <= vidas_d;
      go_q     <= go_d;
      juego_q  <= juego;
    end
  end

  assign mov       = mov_q;
  assign busy      = (estado_q == S_ACCION) || (estado_q == S_ENFRIA) || (estado_q == S_GOLPE);
  assign hit       = hit_q;
  assign score     = score_q;
  assign vidas     = vidas_q;
  assign game_over = go_q;

endmodule
